ysyx_210544_memu: RTL and testbench

Memory-access stage sitting directly downstream of the execute unit and upstream of write-back. It accepts one instruction per handshake and passes non-memory results through after one register stage. Loads and stores drive a single-outstanding, 8-byte-aligned request/acknowledge data-bus port, with byte-lane steering, write strobes and load sign/zero extension. Misaligned accesses are flagged without issuing a bus request.

---
 rtl/ysyx_210544_memu.sv | 171 +++++++++++++++++
 tb/tb_ysyx_210544_memu.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_210544_memu.sv
// Memory-access stage: forwards execute results, or performs one aligned
// load/store on a single-outstanding 8-byte-aligned request/ack data bus.
module ysyx_210544_memu (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [7:0]  i_inst_opcode,
  input  logic [4:0]  i_rd,
  input  logic        i_rd_wen,
  input  logic [63:0] i_addr,
  input  logic [63:0] i_wdata,
  input  logic [63:0] i_exe_rd_wdata,
  output logic        o_mem_req,
  output logic        o_mem_wen,
  output logic [63:0] o_mem_addr,
  output logic [63:0] o_mem_wdata,
  output logic [7:0]  o_mem_wstrb,
  input  logic        i_mem_ack,
  input  logic [63:0] i_mem_rdata,
  output logic        o_valid,
  output logic [4:0]  o_rd,
  output logic        o_rd_wen,
  output logic [63:0] o_rd_wdata,
  output logic        o_misalign
);

  // Opcode values mirror the INST_* codes of the shared defines header.
  localparam logic [7:0] INST_LB  = 8'h10;
  localparam logic [7:0] INST_LH  = 8'h11;
  localparam logic [7:0] INST_LW  = 8'h12;
  localparam logic [7:0] INST_LD  = 8'h13;
  localparam logic [7:0] INST_LBU = 8'h14;
  localparam logic [7:0] INST_LHU = 8'h15;
  localparam logic [7:0] INST_LWU = 8'h16;
  localparam logic [7:0] INST_SB  = 8'h17;
  localparam logic [7:0] INST_SH  = 8'h18;
  localparam logic [7:0] INST_SW  = 8'h19;
  localparam logic [7:0] INST_SD  = 8'h1A;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state;
  logic [2:0]  lane;
  logic [7:0]  op_q;
  logic [4:0]  rd_q;
  logic        rd_wen_q;
  logic        load_q;

  logic        is_load;
  logic        is_store;
  logic [1:0]  size;
  logic        misal;
  logic [7:0]  strb_base;
  logic        xfer;
  logic [63:0] ld_x;
  logic [63:0] ld_data;

  assign o_ready = (state != BUS);
  assign xfer    = i_valid && o_ready;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    size     = 2'd0;
    case (i_inst_opcode)
      INST_LB, INST_LBU: begin is_load = 1'b1;  size = 2'd0; end
      INST_LH, INST_LHU: begin is_load = 1'b1;  size = 2'd1; end
      INST_LW, INST_LWU: begin is_load = 1'b1;  size = 2'd2; end
      INST_LD:           begin is_load = 1'b1;  size = 2'd3; end
      INST_SB:           begin is_store = 1'b1; size = 2'd0; end
      INST_SH:           begin is_store = 1'b1; size = 2'd1; end
      INST_SW:           begin is_store = 1'b1; size = 2'd2; end
      INST_SD:           begin is_store = 1'b1; size = 2'd3; end
      default: ;
    endcase
  end

  always_comb begin
    misal     = 1'b0;
    strb_base = 8'h01;
    case (size)
      2'd0: begin misal = 1'b0;            strb_base = 8'h01; end
      2'd1: begin misal = i_addr[0];       strb_base = 8'h03; end
      2'd2: begin misal = |i_addr[1:0];    strb_base = 8'h0F; end
      2'd3: begin misal = |i_addr[2:0];    strb_base = 8'hFF; end
      default: ;
    endcase
  end

  // Load data is steered from the registered lane of the outstanding access.
  always_comb begin
    ld_x    = i_mem_rdata >> {lane, 3'b000};
    ld_data = ld_x;
    case (op_q)
      INST_LB:  ld_data = {{56{ld_x[7]}}, ld_x[7:0]};
      INST_LBU: ld_data = {56'd0, ld_x[7:0]};
      INST_LH:  ld_data = {{48{ld_x[15]}}, ld_x[15:0]};
      INST_LHU: ld_data = {48'd0, ld_x[15:0]};
      INST_LW:  ld_data = {{32{ld_x[31]}}, ld_x[31:0]};
      INST_LWU: ld_data = {32'd0, ld_x[31:0]};
      default:  ld_data = ld_x;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      lane        <= '0;
      op_q        <= '0;
      rd_q        <= '0;
      rd_wen_q    <= 1'b0;
      load_q      <= 1'b0;
      o_mem_req   <= 1'b0;
      o_mem_wen   <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_wstrb <= '0;
      o_valid     <= 1'b0;
      o_rd        <= '0;
      o_rd_wen    <= 1'b0;
      o_rd_wdata  <= '0;
      o_misalign  <= 1'b0;
    end else if (state == BUS) begin
      if (i_mem_ack) begin
        state       <= RESP;
        o_mem_req   <= 1'b0;
        o_mem_wen   <= 1'b0;
        o_mem_wstrb <= '0;
        o_valid     <= 1'b1;
        o_rd        <= rd_q;
        o_rd_wen    <= load_q & rd_wen_q;
        o_rd_wdata  <= load_q ? ld_data : '0;
      end
    end else begin
      o_valid    <= 1'b0;
      o_misalign <= 1'b0;
      if (!xfer) begin
        state <= IDLE;
      end else if (!(is_load || is_store)) begin
        state      <= RESP;
        o_valid    <= 1'b1;
        o_rd       <= i_rd;
        o_rd_wen   <= i_rd_wen;
        o_rd_wdata <= i_exe_rd_wdata;
      end else if (misal) begin
        state      <= RESP;
        o_valid    <= 1'b1;
        o_misalign <= 1'b1;
        o_rd       <= i_rd;
        o_rd_wen   <= 1'b0;
        o_rd_wdata <= '0;
      end else begin
        state       <= BUS;
        lane        <= i_addr[2:0];
        op_q        <= i_inst_opcode;
        rd_q        <= i_rd;
        rd_wen_q    <= i_rd_wen;
        load_q      <= is_load;
        o_mem_req   <= 1'b1;
        o_mem_wen   <= is_store;
        o_mem_addr  <= {i_addr[63:3], 3'b000};
        o_mem_wdata <= is_store ? (i_wdata << {i_addr[2:0], 3'b000}) : '0;
        o_mem_wstrb <= is_store ? (strb_base << i_addr[2:0]) : '0;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_210544_memu.sv
// Self-checking bench for ysyx_210544_memu: vector table driven through a
// transaction task, results checked by a scoreboard on o_valid.
module tb_ysyx_210544_memu;

  localparam logic [7:0] ADD = 8'h01, LB = 8'h10, LH = 8'h11, LW = 8'h12,
                         LD = 8'h13, LBU = 8'h14, LHU = 8'h15, LWU = 8'h16,
                         SB = 8'h17, SH = 8'h18, SW = 8'h19, SDD = 8'h1A;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic [7:0]  i_inst_opcode;
  logic [4:0]  i_rd;
  logic        i_rd_wen;
  logic [63:0] i_addr, i_wdata, i_exe_rd_wdata;
  logic        o_mem_req, o_mem_wen;
  logic [63:0] o_mem_addr, o_mem_wdata;
  logic [7:0]  o_mem_wstrb;
  logic        i_mem_ack;
  logic [63:0] i_mem_rdata;
  logic        o_valid;
  logic [4:0]  o_rd;
  logic        o_rd_wen;
  logic [63:0] o_rd_wdata;
  logic        o_misalign;

  ysyx_210544_memu dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_inst_opcode(i_inst_opcode), .i_rd(i_rd), .i_rd_wen(i_rd_wen),
    .i_addr(i_addr), .i_wdata(i_wdata), .i_exe_rd_wdata(i_exe_rd_wdata),
    .o_mem_req(o_mem_req), .o_mem_wen(o_mem_wen), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
    .o_valid(o_valid), .o_rd(o_rd), .o_rd_wen(o_rd_wen),
    .o_rd_wdata(o_rd_wdata), .o_misalign(o_misalign)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // kind: 0 = non-memory, 1 = load, 2 = store
  typedef struct {
    logic [7:0]  op;
    int          kind;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    int          wt;
    logic [63:0] exp_data;
    logic        exp_wen;
    logic        exp_mis;
    logic [7:0]  exp_strb;
    logic [63:0] exp_mw;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic        rd_wen;
    logic [63:0] data;
    logic        mis;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] op, input int kind,
                              input logic [63:0] addr, input logic [63:0] wdata,
                              input logic [63:0] rdata, input int wt,
                              input logic [63:0] exp_data, input logic exp_wen,
                              input logic exp_mis, input logic [7:0] exp_strb,
                              input logic [63:0] exp_mw);
    vec_t v;
    v.op = op; v.kind = kind; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.wt = wt; v.exp_data = exp_data; v.exp_wen = exp_wen; v.exp_mis = exp_mis;
    v.exp_strb = exp_strb; v.exp_mw = exp_mw;
    return v;
  endfunction

  // Scoreboard: every o_valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (o_valid) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_valid: got o_valid=1 expected 0 (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("valid_cycle", 64'(cyc), 64'(mon_e.cyc));
        check("o_rd", 64'(o_rd), 64'(mon_e.rd));
        check("o_rd_wen", 64'(o_rd_wen), 64'(mon_e.rd_wen));
        check("o_rd_wdata", o_rd_wdata, mon_e.data);
        check("o_misalign", 64'(o_misalign), 64'(mon_e.mis));
      end
    end
  end

  // Called at a negedge; returns at a negedge with the stage ready again.
  task automatic issue(input vec_t v, input logic [4:0] rd);
    int   t;
    exp_t e;
    i_inst_opcode  = v.op;
    i_rd           = rd;
    i_rd_wen       = 1'b1;
    i_addr         = v.addr;
    i_wdata        = v.wdata;
    i_exe_rd_wdata = (v.kind == 0) ? 64'h1234 : 64'hBAD0_BAD0_BAD0_BAD0;
    i_valid        = 1'b1;
    check("o_ready", 64'(o_ready), 64'd1);
    t = cyc + 1;
    e.rd = rd; e.rd_wen = v.exp_wen; e.data = v.exp_data; e.mis = v.exp_mis;
    e.cyc = (v.kind != 0 && !v.exp_mis) ? t + v.wt + 1 : t;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    if (v.kind == 0 || v.exp_mis) begin
      check("no_req", 64'(o_mem_req), 64'd0);
    end else begin
      check("req", 64'(o_mem_req), 64'd1);
      check("mem_addr", o_mem_addr, {v.addr[63:3], 3'b000});
      check("mem_wen", 64'(o_mem_wen), 64'(v.kind == 2));
      check("mem_wstrb", 64'(o_mem_wstrb), 64'(v.exp_strb));
      if (v.kind == 2) check("mem_wdata", o_mem_wdata, v.exp_mw);
      for (int k = 0; k < v.wt; k++) begin
        @(negedge clk);
        check("req_held", 64'(o_mem_req), 64'd1);
        check("addr_held", o_mem_addr, {v.addr[63:3], 3'b000});
      end
      i_mem_ack   = 1'b1;
      i_mem_rdata = v.rdata;
      @(negedge clk);
      i_mem_ack   = 1'b0;
      i_mem_rdata = 64'h5555_AAAA_5555_AAAA;
      check("req_drop", 64'(o_mem_req), 64'd0);
      check("wstrb_drop", 64'(o_mem_wstrb), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(ADD, 0, 64'h0, 64'h0, 64'h0, 0, 64'h1234, 1'b1, 1'b0, 8'h00, 64'h0);
    vecs[1]  = mk(LB,  1, 64'h8000_0003, 64'h0, 64'h0000_0000_8000_0000, 2,
                  64'hFFFF_FFFF_FFFF_FF80, 1'b1, 1'b0, 8'h00, 64'h0);
    vecs[2]  = mk(LWU, 1, 64'h8000_0004, 64'h0, 64'hDEAD_BEEF_0000_0000, 0,
                  64'h0000_0000_DEAD_BEEF, 1'b1, 1'b0, 8'h00, 64'h0);
    vecs[3]  = mk(LHU, 1, 64'h8000_0006, 64'h0, 64'hDEAD_BEEF_0000_0000, 1,
                  64'h0000_0000_0000_DEAD, 1'b1, 1'b0, 8'h00, 64'h0);
    vecs[4]  = mk(SH,  2, 64'h8000_0002, 64'hABCD, 64'h0, 0,
                  64'h0, 1'b0, 1'b0, 8'h0C, 64'h0000_0000_ABCD_0000);
    vecs[5]  = mk(LW,  1, 64'h8000_0002, 64'h0, 64'h0, 0, 64'h0, 1'b0, 1'b1, 8'h00, 64'h0);
    vecs[6]  = mk(LD,  1, 64'h8000_0008, 64'h0, 64'h0123_4567_89AB_CDEF, 1,
                  64'h0123_4567_89AB_CDEF, 1'b1, 1'b0, 8'h00, 64'h0);
    vecs[7]  = mk(LH,  1, 64'h8000_0002, 64'h0, 64'h0000_0000_8001_0000, 0,
                  64'hFFFF_FFFF_FFFF_8001, 1'b1, 1'b0, 8'h00, 64'h0);
    vecs[8]  = mk(SB,  2, 64'h8000_0005, 64'h5A, 64'h0, 0,
                  64'h0, 1'b0, 1'b0, 8'h20, 64'h0000_5A00_0000_0000);
    vecs[9]  = mk(SDD, 2, 64'h8000_0010, 64'h1122_3344_5566_7788, 64'h0, 2,
                  64'h0, 1'b0, 1'b0, 8'hFF, 64'h1122_3344_5566_7788);
    vecs[10] = mk(SW,  2, 64'h8000_0014, 64'hCAFE_BABE, 64'h0, 0,
                  64'h0, 1'b0, 1'b0, 8'hF0, 64'hCAFE_BABE_0000_0000);
    vecs[11] = mk(LBU, 1, 64'h8000_0007, 64'h0, 64'h9A00_0000_0000_0000, 0,
                  64'h0000_0000_0000_009A, 1'b1, 1'b0, 8'h00, 64'h0);
    vecs[12] = mk(LD,  1, 64'h8000_0004, 64'h0, 64'h0, 0, 64'h0, 1'b0, 1'b1, 8'h00, 64'h0);
    vecs[13] = mk(SH,  2, 64'h8000_0001, 64'hFFFF, 64'h0, 0, 64'h0, 1'b0, 1'b1, 8'h00, 64'h0);
    vecs[14] = mk(LB,  1, 64'h8000_0000, 64'h0, 64'hFFFF_FFFF_FFFF_FF7F, 0,
                  64'h0000_0000_0000_007F, 1'b1, 1'b0, 8'h00, 64'h0);

    rst = 1'b1; i_valid = 1'b0; i_inst_opcode = '0; i_rd = '0; i_rd_wen = 1'b0;
    i_addr = '0; i_wdata = '0; i_exe_rd_wdata = '0; i_mem_ack = 1'b0; i_mem_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(o_ready), 64'd1);
    check("rst_req", 64'(o_mem_req), 64'd0);
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_rd_wdata", o_rd_wdata, 64'd0);
    check("rst_mem_addr", o_mem_addr, 64'd0);
    check("rst_wstrb", 64'(o_mem_wstrb), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back non-memory stream: three consecutive transfers.
    for (int i = 0; i < 3; i++) issue(vecs[0], 5'd5);
    @(negedge clk);

    for (int i = 1; i < 15; i++) issue(vecs[i], 5'(i + 1));
    issue(vecs[0], 5'd7);
    @(negedge clk);

    // Ack while idle must be ignored.
    i_mem_ack = 1'b1;
    @(negedge clk);
    i_mem_ack = 1'b0;
    check("idle_ack_req", 64'(o_mem_req), 64'd0);
    check("idle_ack_valid", 64'(o_valid), 64'd0);

    // Reset during BUS aborts the load; a late ack produces nothing.
    i_inst_opcode = LD; i_rd = 5'd9; i_rd_wen = 1'b1; i_addr = 64'h8000_0020;
    i_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    check("abort_req_before", 64'(o_mem_req), 64'd1);
    check("abort_ready_bus", 64'(o_ready), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_req_after", 64'(o_mem_req), 64'd0);
    check("abort_ready", 64'(o_ready), 64'd1);
    i_mem_ack = 1'b1; i_mem_rdata = 64'hFFFF_0000_FFFF_0000;
    @(negedge clk);
    i_mem_ack = 1'b0;
    check("abort_late_valid", 64'(o_valid), 64'd0);
    @(negedge clk);
    check("abort_late_valid2", 64'(o_valid), 64'd0);
    issue(vecs[0], 5'd3);

    repeat (4) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
